readout_collector: RTL

- Downstream consumer of the per-block serial readout FIFOs, running in the fifo_clk domain.
- Polls NUM_BLOCKS blocks round-robin. Pulses the chosen block's fifo_req and deserialises its 36-bit word ({meta, D}) from fifo_bit.
- Presents each word with the source block index on a valid/ready output to the host link.
- Owns the shared fifo_rst and tracks per-block overflow flags.

---
 rtl/readout_collector_if.sv | 24 ++
 rtl/readout_collector.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/readout_collector_if.sv
// Host-side word link of the readout collector.
// Valid/ready handshake carrying a 36-bit word and its source block.
interface readout_collector_if #(
  parameter int IDX_W = 4
);
  logic [35:0]      out_data;
  logic [IDX_W-1:0] out_block;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_block,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_block,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/readout_collector.sv
// Round-robin collector for per-block serial readout FIFOs.
// Owns the shared FIFO reset and the sticky overflow flags.
module readout_collector #(
  parameter int NUM_BLOCKS = 4,
  parameter int IDX_W      = 4,
  parameter int RST_HOLD   = 8,
  parameter int RST_QUIET  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [NUM_BLOCKS-1:0] fifo_empty,
  input  logic [NUM_BLOCKS-1:0] fifo_oflow,
  input  logic [NUM_BLOCKS-1:0] fifo_bit,
  output logic [NUM_BLOCKS-1:0] fifo_req,
  output logic                  fifo_rst,
  output logic [NUM_BLOCKS-1:0] oflow_seen,
  output logic                  busy,
  readout_collector_if.master   host
);

  localparam int PTR_W =
    (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] QUIET_LAST =
    CNT_W'(RST_QUIET - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(35);
  localparam logic [PTR_W-1:0] PTR_INIT =
    PTR_W'(NUM_BLOCKS - 1);

  typedef enum logic [2:0] {
    RST_FIFO,
    QUIET,
    SCAN,
    REQ,
    SHIFT,
    DELIVER
  } state_t;

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [PTR_W-1:0]        ptr, ptr_n;
  logic [PTR_W-1:0]        pick, idx;
  logic                    found;
  logic [35:0]             shift;
  logic [35:0]             word;
  logic                    load;
  logic                    free;
  logic                    bit_in;
  logic [NUM_BLOCKS-1:0]   req_n;

  assign bit_in = fifo_bit[ptr];
  assign free   = !host.out_valid || host.out_ready;
  assign busy   = (state != SCAN);

  // Nearest non-empty block after ptr wins; ptr itself is last.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    idx   = ptr;
    for (int k = NUM_BLOCKS; k >= 1; k--) begin
      idx = PTR_W'((int'(ptr) + k) % NUM_BLOCKS);
      if (!fifo_empty[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Next state, counters and word-load decision.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ptr_n   = ptr;
    load    = 1'b0;
    word    = shift;
    unique case (state)
      RST_FIFO: begin
        if (cnt == HOLD_LAST) begin
          state_n = QUIET;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      QUIET: begin
        if (cnt == QUIET_LAST) begin
          state_n = SCAN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      SCAN: begin
        if (found) begin
          ptr_n   = pick;
          cnt_n   = '0;
          state_n = REQ;
        end
      end
      REQ: begin
        cnt_n   = '0;
        state_n = SHIFT;
      end
      SHIFT: begin
        cnt_n = cnt + CNT_W'(1);
        if (cnt == BIT_LAST) begin
          // Last bit goes straight to the output if it is free.
          word    = {bit_in, shift[34:0]};
          cnt_n   = '0;
          load    = free;
          state_n = free ? SCAN : DELIVER;
        end
      end
      DELIVER: begin
        if (free) begin
          load    = 1'b1;
          state_n = SCAN;
        end
      end
      default: begin
        state_n = RST_FIFO;
        cnt_n   = '0;
      end
    endcase
    if (flush) begin
      state_n = RST_FIFO;
      cnt_n   = '0;
      load    = 1'b0;
    end
    req_n = '0;
    if (state_n == REQ) begin
      req_n[ptr_n] = 1'b1;
    end
  end

  // State, counter and round-robin pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RST_FIFO;
      cnt   <= '0;
      ptr   <= PTR_INIT;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ptr   <= ptr_n;
    end
  end

  // Registered FIFO strobes derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_req <= '0;
      fifo_rst <= 1'b1;
    end else begin
      fifo_req <= req_n;
      fifo_rst <= (state_n == RST_FIFO);
    end
  end

  // Deserialiser: bit k lands in shift[k].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift <= '0;
    end else if (flush) begin
      shift <= '0;
    end else if (state == SHIFT) begin
      shift[cnt[5:0]] <= bit_in;
    end
  end

  // Host output register with same-cycle accept and reload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host.out_data  <= '0;
      host.out_block <= '0;
      host.out_valid <= 1'b0;
    end else if (flush) begin
      host.out_valid <= 1'b0;
    end else if (load) begin
      host.out_data  <= word;
      host.out_block <= IDX_W'(ptr);
      host.out_valid <= 1'b1;
    end else if (host.out_ready) begin
      host.out_valid <= 1'b0;
    end
  end

  // Sticky overflow flags, ignored while the FIFOs are resetting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oflow_seen <= '0;
    end else if (flush) begin
      oflow_seen <= '0;
    end else if (state != RST_FIFO && state != QUIET) begin
      oflow_seen <= oflow_seen | fifo_oflow;
    end
  end

endmodule
